hack_run_ctrl: RTL and testbench
================================

HACK_RUN_CTRL -- requirements
Module: hack_run_ctrl

Interface
REQ-001 Parameter NARGS, default 2: number of argument words written to RAM[0..NARGS-1] before each run.
REQ-002 Parameter RESULT_ADDR, default 2: RAM address read back as the run result.
REQ-003 Parameter MAX_CYCLES, default 1024: RUN cycle budget, range 1..65535.
REQ-004 Parameter HALT_REPEAT, default 4: consecutive halt-pattern matches that declare a halt, range 1..15.
REQ-005 clk  in  1  system clock; all logic is rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  run request; sampled only in IDLE.
REQ-008 abort  in  1  cancel the current run.
REQ-009 arg_data  in  16*NARGS  argument words; word i is bits [16i+15:16i]; latched on start acceptance.
REQ-010 cpu_pc  in  15  Hack CPU program counter.
REQ-011 ram_rdata  in  16  data-RAM combinational read of ram_addr.
REQ-012 cpu_reset  out  1  drives the Computer reset; data RAM host port owns the RAM while this is high.
REQ-013 ram_we, ram_addr, ram_wdata  out  1/15/16  host write/read port to data RAM.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 timeout  out  1  qualifies done; held until the next start.
REQ-017 result  out  16  RAM[RESULT_ADDR] captured at the end of the last completed run.
REQ-018 cycles  out  16  RUN-cycle count of the last run, held until the next start.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and READ, with all outputs registered.
REQ-020 IDLE: cpu_reset=1, ram_we=0; start=1 and abort=0 SHALL latch arg_data, clear timeout and cycles, set idx=0, and go to LOAD.
REQ-021 LOAD: ram_we=1, ram_addr=idx, ram_wdata=arg word idx; idx increments each cycle; after the write of idx=NARGS-1, go to RUN (NARGS cycles, cpu_reset still 1).
REQ-022 RUN: cpu_reset=0, ram_we=0; cycles increments every RUN cycle.
REQ-023 Halt pattern: cpu_pc == pc delayed two cycles, evaluated only from the 3rd RUN cycle onward; this covers the self-loop and the two-instruction Hack "@END;0;JMP" loop.
REQ-024 The match counter SHALL reset to 0 on a mismatch; when it reaches HALT_REPEAT, go to READ with timeout=0.
REQ-025 When cycles reaches MAX_CYCLES without a halt, go to READ with timeout=1; if halt and budget expiry coincide, halt wins (timeout=0).
REQ-026 READ (1 cycle): cpu_reset=1, ram_addr=RESULT_ADDR, result<=ram_rdata; then go to IDLE with done=1 for exactly the first IDLE cycle.
REQ-027 abort=1 in LOAD, RUN or READ SHALL go to IDLE next cycle with cpu_reset=1, no done, and result unchanged.
REQ-028 start while busy SHALL be ignored; start and abort together in IDLE SHALL keep IDLE.
REQ-029 ram_addr SHALL be 0 and ram_wdata SHALL be 0 whenever the port is unused.

Reset
REQ-030 reset SHALL force IDLE with cpu_reset=1, busy=0, done=0, timeout=0, ram_we=0, result=0, cycles=0, and all counters 0; it overrides every other input, including mid-run.

Configuration
REQ-031 With macro HACK_RUN_CTRL_CLEAR_EN defined, LOAD SHALL add one final cycle writing 0 to RESULT_ADDR (NARGS+1 LOAD cycles); without it, RESULT_ADDR is not written and LOAD lasts NARGS cycles.

Verification
REQ-032 NARGS=2, start with args (2,3): ram_we high 2 cycles writing addr0=2 then addr1=3; cpu_reset falls the next cycle.
REQ-033 Scripted cpu_pc 0..9, then alternating 10/11, HALT_REPEAT=4, RAM model RAM[2]=6: after 4 matches, one READ cycle, then done=1 for one cycle, result=6, timeout=0, cpu_reset=1.
REQ-034 cpu_pc incrementing forever, MAX_CYCLES=100: done with timeout=1 and cycles=100; halt on exactly cycle 100 gives timeout=0.
REQ-035 abort on the 5th RUN cycle: next cycle busy=0 and cpu_reset=1; done is never asserted; result keeps its prior value (6).
REQ-036 start during RUN is ignored (no restart, cycles keeps counting); start+abort in IDLE leaves busy=0; reset asserted in LOAD gives all outputs their reset values next cycle.
REQ-037 With HACK_RUN_CTRL_CLEAR_EN defined: a third write (addr2=0) occurs and cpu_reset falls one cycle later than without the macro.

Source files
------------

// File: rtl/hack_run_ctrl.sv
// Host-side run controller for a Hack Computer: loads arguments, runs the CPU until it halts or times out, reads back the result.
// Optional macro HACK_RUN_CTRL_CLEAR_EN adds a final LOAD cycle that zeroes RAM[RESULT_ADDR].
module hack_run_ctrl #(
  parameter int NARGS       = 2,
  parameter int RESULT_ADDR = 2,
  parameter int MAX_CYCLES  = 1024,
  parameter int HALT_REPEAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [16*NARGS-1:0]  arg_data,
  input  logic [14:0]          cpu_pc,
  input  logic [15:0]          ram_rdata,
  output logic                 cpu_reset,
  output logic                 ram_we,
  output logic [14:0]          ram_addr,
  output logic [15:0]          ram_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          result,
  output logic [15:0]          cycles
);

  localparam int IW   = $clog2(NARGS + 1);
  localparam int PADW = 16 * (2 ** IW);
  localparam logic [14:0] RES_ADDR = 15'(RESULT_ADDR);
  localparam logic [15:0] MAX_N    = 16'(MAX_CYCLES);
  localparam logic [3:0]  HALT_N   = 4'(HALT_REPEAT);
  localparam logic [IW-1:0] NARGS_N = IW'(NARGS);
`ifdef HACK_RUN_CTRL_CLEAR_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NARGS);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(NARGS - 1);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, READ} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [16*NARGS-1:0] args_q, args_d;
  logic [PADW-1:0]     argsPad;
  logic [15:0]         cycles_q, cycles_d;
  logic [3:0]          match_q, match_d;
  logic [14:0]         pc1_q, pc1_d, pc2_q, pc2_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         result_q, result_d;
  logic                cpuReset_q, cpuReset_d;
  logic                ramWe_q, ramWe_d;
  logic [14:0]         ramAddr_q, ramAddr_d;
  logic [15:0]         ramWdata_q, ramWdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  assign argsPad = PADW'(args_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      args_q     <= '0;
      cycles_q   <= '0;
      match_q    <= '0;
      pc1_q      <= '0;
      pc2_q      <= '0;
      timeout_q  <= 1'b0;
      result_q   <= '0;
      cpuReset_q <= 1'b1;
      ramWe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      args_q     <= args_d;
      cycles_q   <= cycles_d;
      match_q    <= match_d;
      pc1_q      <= pc1_d;
      pc2_q      <= pc2_d;
      timeout_q  <= timeout_d;
      result_q   <= result_d;
      cpuReset_q <= cpuReset_d;
      ramWe_q    <= ramWe_d;
      ramAddr_q  <= ramAddr_d;
      ramWdata_q <= ramWdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    args_d    = args_q;
    cycles_d  = cycles_q;
    match_d   = match_q;
    pc1_d     = pc1_q;
    pc2_d     = pc2_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          args_d    = arg_data;
          timeout_d = 1'b0;
          cycles_d  = '0;
          idx_d     = '0;
          match_d   = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          match_d = '0;
          state_d = IDLE;
        end else begin
          cycles_d = cycles_q + 16'd1;
          pc1_d    = cpu_pc;
          pc2_d    = pc1_q;
          // pc2_q only holds a real RUN-cycle pc from the third cycle on
          if ((cycles_q >= 16'd2) && (cpu_pc == pc2_q)) begin
            match_d = match_q + 4'd1;
          end else begin
            match_d = '0;
          end
          if (match_d == HALT_N) begin
            match_d   = '0;
            timeout_d = 1'b0;
            state_d   = READ;
          end else if (cycles_d == MAX_N) begin
            match_d   = '0;
            timeout_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      READ: begin
        state_d = IDLE;
        if (!abort) begin
          result_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    cpuReset_d = (state_d != RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == READ) && !abort;
    ramWe_d    = 1'b0;
    ramAddr_d  = '0;
    ramWdata_d = '0;
    unique case (state_d)
      LOAD: begin
        ramWe_d = 1'b1;
        if (idx_d < NARGS_N) begin
          ramAddr_d  = 15'(idx_d);
          ramWdata_d = argsPad[16*idx_d +: 16];
        end else begin
          ramAddr_d = RES_ADDR;
        end
      end
      READ:    ramAddr_d = RES_ADDR;
      default: ;
    endcase
  end

  assign cpu_reset = cpuReset_q;
  assign ram_we    = ramWe_q;
  assign ram_addr  = ramAddr_q;
  assign ram_wdata = ramWdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign result    = result_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Scoreboard bench for hack_run_ctrl with a scripted CPU pc model and a small data-RAM model.
// Honours HACK_RUN_CTRL_CLEAR_EN for the extra LOAD write.
module tb_hack_run_ctrl;
  localparam int NARGS       = 2;
  localparam int RESULT_ADDR = 2;
  localparam int MAX_CYCLES  = 100;
  localparam int HALT_REPEAT = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] arg_data;
  logic [14:0] cpu_pc;
  logic [15:0] ram_rdata;
  logic        cpu_reset, ram_we, busy, done, timeout;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata, result, cycles;

  logic [15:0] ram [16];
  int          runK;
  int          loopStart = 1000000;
  logic [15:0] cpuResult = '0;
  int          nChecks = 0;
  int          nFails = 0;

  typedef struct {
    logic [15:0] res;
    logic        to;
    logic [15:0] cyc;
  } exp_t;
  exp_t sbQ[$];

  hack_run_ctrl #(
    .NARGS(NARGS), .RESULT_ADDR(RESULT_ADDR),
    .MAX_CYCLES(MAX_CYCLES), .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .arg_data(arg_data), .cpu_pc(cpu_pc), .ram_rdata(ram_rdata),
    .cpu_reset(cpu_reset), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .timeout(timeout),
    .result(result), .cycles(cycles)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[3:0]];

  // Counts up until loopStart, then bounces between two addresses like "@END;0;JMP".
  function automatic logic [14:0] pcFor(int k, int ls);
    if (k <= 0) return '0;
    if (k < ls) return 15'(k - 1);
    return 15'(ls - 1 + ((k - ls) % 2));
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // CPU and RAM model: host writes win, the CPU stores its answer on its 3rd run cycle.
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    runK   = 0;
    cpu_pc = '0;
    forever begin
      @(posedge clk);
      if (ram_we === 1'b1) ram[ram_addr[3:0]] = ram_wdata;
      else if (cpu_reset === 1'b0 && runK == 3) ram[4'(RESULT_ADDR)] = cpuResult;
      #1;
      if (cpu_reset !== 1'b0) runK = 0;
      else runK++;
      cpu_pc = pcFor(runK, loopStart);
    end
  end

  // Monitor: every done pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("done unexpected", 32'(done), 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb result", 32'(result), 32'(e.res));
          checkOutput("sb timeout", 32'(timeout), 32'(e.to));
          checkOutput("sb cycles", 32'(cycles), 32'(e.cyc));
          checkOutput("sb cpu_reset", 32'(cpu_reset), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(logic [31:0] args, int ls, logic [15:0] res,
                               logic expTo, logic [15:0] expCyc, bit doPush);
    exp_t e;
    arg_data  = args;
    loopStart = ls;
    cpuResult = res;
    if (doPush) begin
      e.res = res; e.to = expTo; e.cyc = expCyc;
      sbQ.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    arg_data = '0;
  endtask

  task automatic checkLoad(logic [15:0] a0, logic [15:0] a1);
    checkOutput("load0 we", 32'(ram_we), 32'd1);
    checkOutput("load0 addr", 32'(ram_addr), 32'd0);
    checkOutput("load0 data", 32'(ram_wdata), 32'(a0));
    checkOutput("load0 cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("load0 busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("load1 we", 32'(ram_we), 32'd1);
    checkOutput("load1 addr", 32'(ram_addr), 32'd1);
    checkOutput("load1 data", 32'(ram_wdata), 32'(a1));
    checkOutput("load1 cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef HACK_RUN_CTRL_CLEAR_EN
    @(negedge clk);
    checkOutput("clear we", 32'(ram_we), 32'd1);
    checkOutput("clear addr", 32'(ram_addr), 32'(RESULT_ADDR));
    checkOutput("clear data", 32'(ram_wdata), 32'd0);
    checkOutput("clear cpu_reset", 32'(cpu_reset), 32'd1);
`endif
    @(negedge clk);
    checkOutput("run cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("run we", 32'(ram_we), 32'd0);
    checkOutput("run addr", 32'(ram_addr), 32'd0);
  endtask

  task automatic waitRunEnd();
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = (cpu_reset === 1'b1);
    end
    checkOutput("run end reached", 32'(found), 32'd1);
    checkOutput("read addr", 32'(ram_addr), 32'(RESULT_ADDR));
    checkOutput("read busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, " we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, " addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, " wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, " result"}, 32'(result), 32'd0);
    checkOutput({tag, " cycles"}, 32'(cycles), 32'd0);
  endtask

  initial begin
    bit hit;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    arg_data = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] run A: halt after loop at pc 10/11");
    applyStimulus(32'h0003_0002, 11, 16'd6, 1'b0, 16'd16, 1'b1);
    checkLoad(16'd2, 16'd3);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start in run busy", 32'(busy), 32'd1);
    checkOutput("start in run cpu_reset", 32'(cpu_reset), 32'd0);
    waitRunEnd();

    $display("[TB] run B: budget expiry");
    applyStimulus(32'h0005_0004, 1000000, 16'd20, 1'b1, 16'd100, 1'b1);
    checkLoad(16'd4, 16'd5);
    waitRunEnd();
    checkOutput("timeout held", 32'(timeout), 32'd1);
    checkOutput("cycles held", 32'(cycles), 32'd100);

    $display("[TB] run C: halt coincides with budget");
    applyStimulus(32'h0007_0006, 95, 16'd6, 1'b0, 16'd100, 1'b1);
    checkLoad(16'd6, 16'd7);
    waitRunEnd();

    $display("[TB] run D: abort on 5th run cycle");
    applyStimulus(32'h0009_0008, 1000000, 16'd99, 1'b0, 16'd0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (runK == 5);
    end
    checkOutput("abort point reached", 32'(hit), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("abort result kept", 32'(result), 32'd6);
    checkOutput("abort no done", 32'(done), 32'd0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start+abort busy", 32'(busy), 32'd0);
    checkOutput("start+abort cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("start+abort we", 32'(ram_we), 32'd0);

    $display("[TB] reset during LOAD");
    applyStimulus(32'h000b_000a, 1000000, 16'd1, 1'b0, 16'd0, 1'b0);
    checkOutput("pre-reset load we", 32'(ram_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("mid reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
